vga_text_ctrl: RTL and testbench

- Text-mode VGA timing and cell-address generator: the upstream end of the pixel renderer's char/h_font/v_font/c_valid/cursor interface.
- Generates 640x480@60 sync timing from the 25 MHz pixel clock and maps each visible pixel to a text cell and a pixel position inside that cell.
- Reads the character code from the text buffer RAM (1-cycle read latency).
- Drives the renderer with aligned cell data, plus a blinking cursor flag.

---
 rtl/vga_text_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_ctrl.sv
// Text-mode VGA timing and cell-address generator. Stage 0 counts pixels and cells,
// stage 1 presents aligned cell data to the renderer, stage 2 carries the syncs.
module vga_text_ctrl #(
  parameter int unsigned H_VIS        = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_VIS        = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned CELL_W       = 9,
  parameter int unsigned CELL_H       = 16,
  parameter int unsigned COLS         = 70,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  text_data,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic [11:0] text_addr,
  output logic [7:0]  char,
  output logic [3:0]  h_font,
  output logic [3:0]  v_font,
  output logic        c_valid,
  output logic        cursor,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);
  localparam int unsigned BW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [HW-1:0] HLast  = HW'(HTot - 1);
  localparam logic [HW-1:0] HVisL  = HW'(H_VIS);
  localparam logic [HW-1:0] HSyncS = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HSyncE = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VLast  = VW'(VTot - 1);
  localparam logic [VW-1:0] VVisL  = VW'(V_VIS);
  localparam logic [VW-1:0] VSyncS = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VSyncE = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [3:0]    HfLast = 4'(CELL_W - 1);
  localparam logic [3:0]    VfLast = 4'(CELL_H - 1);
  localparam logic [6:0]    ColsL  = 7'(COLS);
  localparam logic [4:0]    RowsL  = 5'(ROWS);
  localparam logic [11:0]   ColsA  = 12'(COLS);
  localparam logic [BW-1:0] BLast  = BW'(BLINK_FRAMES - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [3:0]    hf_q, hf_d, vf_q, vf_d;
  logic [6:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [11:0]   rbase_q, rbase_d, addr_q;
  logic [3:0]    h_font_q, v_font_q;
  logic          c_valid_q, cursor_q;
  logic          hs1_q, vs1_q, fs1_q, hsync_q, vsync_q, fstart_q;
  logic [BW-1:0] bcnt_q;
  logic          blink_q;
  logic          in_area, hs_n, vs_n, fs_hit;

  always_comb begin
    hcnt_d  = hcnt_q + 1'b1;
    vcnt_d  = vcnt_q;
    hf_d    = hf_q;
    col_d   = col_q;
    vf_d    = vf_q;
    row_d   = row_q;
    rbase_d = rbase_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      hf_d   = '0;
      col_d  = '0;
      if (vcnt_q == VLast) begin
        vcnt_d  = '0;
        vf_d    = '0;
        row_d   = '0;
        rbase_d = '0;
      end else begin
        vcnt_d = vcnt_q + 1'b1;
        if (vcnt_q < VVisL) begin
          if (vf_q == VfLast) begin
            vf_d    = '0;
            row_d   = row_q + 1'b1;
            rbase_d = rbase_q + ColsA;
          end else begin
            vf_d = vf_q + 1'b1;
          end
        end
      end
    end else if (hcnt_q < HVisL) begin
      if (hf_q == HfLast) begin
        hf_d  = '0;
        col_d = col_q + 1'b1;
      end else begin
        hf_d = hf_q + 1'b1;
      end
    end
  end

  assign in_area = (hcnt_q < HVisL) && (vcnt_q < VVisL) && (col_q < ColsL) && (row_q < RowsL);
  assign hs_n    = !((hcnt_q >= HSyncS) && (hcnt_q < HSyncE));
  assign vs_n    = !((vcnt_q >= VSyncS) && (vcnt_q < VSyncE));
  assign fs_hit  = (hcnt_q == '0) && (vcnt_q == '0);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hf_q      <= '0;
      vf_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      rbase_q   <= '0;
      addr_q    <= '0;
      h_font_q  <= '0;
      v_font_q  <= '0;
      c_valid_q <= 1'b0;
      cursor_q  <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      fs1_q     <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      fstart_q  <= 1'b0;
      bcnt_q    <= '0;
      blink_q   <= 1'b1;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hf_q      <= hf_d;
      vf_q      <= vf_d;
      col_q     <= col_d;
      row_q     <= row_d;
      rbase_q   <= rbase_d;
      // Address built from next-state so it is valid alongside the counters it belongs to.
      addr_q    <= rbase_d + {5'b0, col_d};
      h_font_q  <= hf_q;
      v_font_q  <= vf_q;
      c_valid_q <= in_area;
      cursor_q  <= in_area && cursor_en && blink_q &&
                   (col_q == cursor_x) && (row_q == cursor_y);
      hs1_q     <= hs_n;
      vs1_q     <= vs_n;
      fs1_q     <= fs_hit;
      hsync_q   <= hs1_q;
      vsync_q   <= vs1_q;
      fstart_q  <= fs1_q;
      if (fstart_q) begin
        if (bcnt_q == BLast) begin
          bcnt_q  <= '0;
          blink_q <= ~blink_q;
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
      end
    end
  end

  assign text_addr   = addr_q;
  assign char        = text_data;
  assign h_font      = h_font_q;
  assign v_font      = v_font_q;
  assign c_valid     = c_valid_q;
  assign cursor      = cursor_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl: a shrunk-geometry instance checked cycle by cycle against a
// division-based position model, plus a full 640x480 instance checked at hand-picked pixels.
module tb_vga_text_ctrl;

  // Shrunk geometry: 21 x 11 frame, 4x3 cells of 3x2 pixels, blink every 2 frames.
  localparam int SHV = 14, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 7, SVF = 1, SVS = 2, SVB = 1;
  localparam int SCW = 3, SCH = 2, SCOLS = 4, SROWS = 3, SBF = 2;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int SFT = SHT * SVT;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ram(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- shrunk instance ----------------
  logic        rst_s = 1'b0, en_s = 1'b1;
  logic [7:0]  td_s = '0;
  logic [6:0]  cx_s = 7'd1;
  logic [4:0]  cy_s = 5'd1;
  logic [11:0] ta_s;
  logic [7:0]  ch_s;
  logic [3:0]  hf_s, vf_s;
  logic        cv_s, cu_s, hs_s, vs_s, fs_s;

  vga_text_ctrl #(
    .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .CELL_W(SCW), .CELL_H(SCH), .COLS(SCOLS), .ROWS(SROWS), .BLINK_FRAMES(SBF)
  ) u_small (
    .pclk(pclk), .rst(rst_s), .text_data(td_s), .cursor_x(cx_s), .cursor_y(cy_s),
    .cursor_en(en_s), .text_addr(ta_s), .char(ch_s), .h_font(hf_s), .v_font(vf_s),
    .c_valid(cv_s), .cursor(cu_s), .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
  );

  always @(posedge pclk) td_s <= ram(ta_s);

  typedef struct {
    logic        area;
    logic [11:0] addr;
    logic        cv;
    logic [3:0]  hf, vf;
    logic [7:0]  ch;
    logic        cu, hs, vs, fs;
  } exp_t;

  exp_t exp_q[$];
  int   k = 0;
  bit   active = 1'b0;
  logic pen;
  logic [6:0] pcx;
  logic [4:0] pcy;

  function automatic int hp(input int j); return j % SHT; endfunction
  function automatic int vp(input int j); return (j / SHT) % SVT; endfunction
  function automatic bit area(input int j);
    return hp(j) < SHV && vp(j) < SVV && hp(j) / SCW < SCOLS && vp(j) / SCH < SROWS;
  endfunction
  function automatic int addr(input int j);
    return (vp(j) / SCH) * SCOLS + hp(j) / SCW;
  endfunction
  function automatic bit blink(input int j);
    int n;
    n = (j >= 3) ? (j - 3) / SFT + 1 : 0;
    return ((n / SBF) % 2) == 0;
  endfunction

  // Expected outputs of cycle k (k clock edges after reset release).
  function automatic exp_t build(input int kk, input logic en, input logic [6:0] cx,
                                 input logic [4:0] cy);
    exp_t e;
    int j;
    e.area = area(kk);
    e.addr = 12'(addr(kk));
    j      = kk - 1;
    e.cv   = area(j);
    e.hf   = 4'(hp(j) % SCW);
    e.vf   = 4'(vp(j) % SCH);
    e.ch   = ram(12'(addr(j)));
    e.cu   = area(j) && en && blink(j) && (hp(j) / SCW == int'(cx)) && (vp(j) / SCH == int'(cy));
    if (kk >= 2) begin
      j    = kk - 2;
      e.hs = !(hp(j) >= SHV + SHF && hp(j) < SHV + SHF + SHS);
      e.vs = !(vp(j) >= SVV + SVF && vp(j) < SVV + SVF + SVS);
      e.fs = (hp(j) == 0) && (vp(j) == 0);
    end else begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.fs = 1'b0;
    end
    return e;
  endfunction

  initial forever begin
    @(posedge pclk);
    #3;
    if (active) begin
      k++;
      exp_q.push_back(build(k, pen, pcx, pcy));
      pen = en_s;
      pcx = cx_s;
      pcy = cy_s;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge pclk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.area) chk("s_text_addr", 32'(ta_s), 32'(e.addr));
      chk("s_c_valid", 32'(cv_s), 32'(e.cv));
      chk("s_cursor", 32'(cu_s), 32'(e.cu));
      chk("s_hsync", 32'(hs_s), 32'(e.hs));
      chk("s_vsync", 32'(vs_s), 32'(e.vs));
      chk("s_frame_start", 32'(fs_s), 32'(e.fs));
      if (e.cv) begin
        chk("s_h_font", 32'(hf_s), 32'(e.hf));
        chk("s_v_font", 32'(vf_s), 32'(e.vf));
        chk("s_char", 32'(ch_s), 32'(e.ch));
      end
    end
  end

  task automatic chk_reset_s(input string tag);
    chk({tag, "_hsync"}, 32'(hs_s), 32'd1);
    chk({tag, "_vsync"}, 32'(vs_s), 32'd1);
    chk({tag, "_c_valid"}, 32'(cv_s), 32'd0);
    chk({tag, "_cursor"}, 32'(cu_s), 32'd0);
    chk({tag, "_frame_start"}, 32'(fs_s), 32'd0);
    chk({tag, "_h_font"}, 32'(hf_s), 32'd0);
    chk({tag, "_v_font"}, 32'(vf_s), 32'd0);
    chk({tag, "_text_addr"}, 32'(ta_s), 32'd0);
  endtask

  task automatic release_s();
    @(posedge pclk);
    #7;
    rst_s  = 1'b1;
    k      = 0;
    pen    = en_s;
    pcx    = cx_s;
    pcy    = cy_s;
    active = 1'b1;
  endtask

  task automatic run_s(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  task automatic small_seq();
    bit found;
    repeat (3) @(posedge pclk);
    #1;
    chk_reset_s("s_rst0");
    release_s();
    run_s(4 * SFT + 17);
    cx_s = 7'd3; cy_s = 5'd2;
    run_s(2 * SFT);
    cx_s = 7'd4;                    // column outside text area: never shown
    run_s(2 * SFT);
    cx_s = 7'd0; cy_s = 5'd3;       // row outside text area: never shown
    run_s(SFT);
    en_s = 1'b0; cx_s = 7'd2; cy_s = 5'd0;
    run_s(SFT + 50);
    en_s = 1'b1; cx_s = 7'd0; cy_s = 5'd0;
    found = 1'b0;
    for (int i = 0; i < 4 * SHT; i++) begin
      if (hs_s == 1'b0) begin
        found = 1'b1;
        break;
      end
      run_s(1);
    end
    chk("s_hsync_low_seen", 32'(found), 32'd1);
    active = 1'b0;
    exp_q.delete();
    rst_s = 1'b0;
    #1;
    chk_reset_s("s_rst_mid");
    repeat (3) @(posedge pclk);
    release_s();
    run_s(3 * SFT);
    active = 1'b0;
    @(negedge pclk);
    exp_q.delete();
  endtask

  // ---------------- full-size instance ----------------
  logic        rst_b = 1'b0;
  logic [7:0]  td_b = '0;
  logic [11:0] ta_b;
  logic [7:0]  ch_b;
  logic [3:0]  hf_b, vf_b;
  logic        cv_b, cu_b, hs_b, vs_b, fs_b;

  vga_text_ctrl u_big (
    .pclk(pclk), .rst(rst_b), .text_data(td_b), .cursor_x(7'd3), .cursor_y(5'd2),
    .cursor_en(1'b1), .text_addr(ta_b), .char(ch_b), .h_font(hf_b), .v_font(vf_b),
    .c_valid(cv_b), .cursor(cu_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  always @(posedge pclk) td_b <= ram(ta_b);

  typedef enum int {FAddr, FCv, FHf, FVf, FCh, FCu, FHs, FFs} fld_e;
  typedef struct { int cyc; fld_e fld; int val; } vec_t;

  vec_t bq[$];
  int   kb = 0;
  bit   bactive = 1'b0;

  task automatic vec(input int cyc, input fld_e f, input int val);
    vec_t v;
    v.cyc = cyc; v.fld = f; v.val = val;
    bq.push_back(v);
  endtask

  initial forever begin
    @(posedge pclk);
    #1;
    if (bactive) kb++;
  end

  initial forever begin
    vec_t v;
    logic [31:0] act;
    @(negedge pclk);
    while (bactive && bq.size() != 0 && bq[0].cyc == kb) begin
      v = bq.pop_front();
      case (v.fld)
        FAddr:   act = 32'(ta_b);
        FCv:     act = 32'(cv_b);
        FHf:     act = 32'(hf_b);
        FVf:     act = 32'(vf_b);
        FCh:     act = 32'(ch_b);
        FCu:     act = 32'(cu_b);
        FHs:     act = 32'(hs_b);
        default: act = 32'(fs_b);
      endcase
      chk($sformatf("b_%s_cyc%0d", v.fld.name(), v.cyc), act, 32'(v.val));
    end
  end

  task automatic big_seq();
    // Cycle n after release shows text_addr of pixel n and stage-1 data of pixel n-1.
    vec(0, FAddr, 0);
    vec(1, FCv, 1); vec(1, FHf, 0); vec(1, FVf, 0); vec(1, FCh, 8'h5A); vec(1, FFs, 0);
    vec(2, FFs, 1);
    vec(3, FFs, 0);
    vec(630, FCv, 1); vec(630, FHf, 8);
    vec(631, FCv, 0);
    vec(640, FCv, 0);
    vec(641, FCv, 0);
    vec(657, FHs, 1);
    vec(658, FHs, 0);
    vec(753, FHs, 0);
    vec(754, FHs, 1);
    vec(12809, FAddr, 71);
    vec(12810, FCv, 1); vec(12810, FCh, 8'h1D); vec(12810, FHf, 0); vec(12810, FVf, 0);
    vec(24828, FCu, 0);
    vec(25429, FAddr, 139);
    vec(25430, FHf, 8); vec(25430, FVf, 15); vec(25430, FCv, 1);
    vec(25627, FCu, 0);
    vec(25628, FCu, 1);
    vec(25636, FCu, 1);
    vec(25637, FCu, 0);
    vec(37628, FCu, 1);
    vec(38428, FCu, 0);
    repeat (2) @(posedge pclk);
    #1;
    chk("b_rst_hsync", 32'(hs_b), 32'd1);
    chk("b_rst_c_valid", 32'(cv_b), 32'd0);
    @(posedge pclk);
    #2;
    rst_b   = 1'b1;
    kb      = 0;
    bactive = 1'b1;
    while (kb < 38500) @(posedge pclk);
    @(negedge pclk);
    chk("b_vectors_pending", 32'(bq.size()), 32'd0);
    bactive = 1'b0;
  endtask

  initial begin
    fork
      small_seq();
      big_seq();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
